// File: rtl/q_sequencer_if.sv
// Control and timing bundle between the PIC16C5x execute stage and the Q-phase sequencer.
// The sequencer takes the slave side; whatever drives SLEEP/skip/goto takes the master side.
interface q_sequencer_if;
    logic       sleep_req;
    logic       wake;
    logic       skip;
    logic       goto;
    logic [2:0] fetchState;
    logic [2:0] executeState;
    logic       flush;
    logic       inst_done;
    logic       sleeping;

    modport master (
        output sleep_req, wake, skip, goto,
        input  fetchState, executeState, flush, inst_done, sleeping
    );

    modport slave (
        input  sleep_req, wake, skip, goto,
        output fetchState, executeState, flush, inst_done, sleeping
    );
endinterface

// File: rtl/q_sequencer.sv
// Four-phase Q1..Q4 instruction-cycle sequencer for the PIC16C5x core, with
// oscillator start-up delay, SLEEP/wake handling and skip/goto pipeline flush.
module q_sequencer #(
    parameter int STARTUP_CLKS = 16,
    parameter int WAKE_CLKS    = 8,
    parameter int CNT_W        = 8
) (
    input  logic          clk,
    input  logic          rst,
    q_sequencer_if.slave  bus
);

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_SLEEP = 2'd2;
    localparam logic [1:0] ST_WAKE  = 2'd3;

    localparam logic [2:0]       PH_HALT    = 3'd4;
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(STARTUP_CLKS - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CLKS - 1);

    logic [1:0]       state;
    logic [1:0]       q;
    logic [CNT_W-1:0] cnt;
    logic             pend;
    logic             running;

    // pend starts set so the very first instruction after reset executes as a NOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_START;
            q     <= 2'd0;
            cnt   <= '0;
            pend  <= 1'b1;
        end else begin
            case (state)
                ST_START: begin
                    if (cnt == START_LAST) begin
                        state <= ST_RUN;
                        q     <= 2'd0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    q <= q + 2'd1;
                    if (q == 2'd0) begin
                        pend <= 1'b0;
                    end
                    // The cycle in Q4 always completes; SLEEP takes effect afterwards.
                    if (q == 2'd3) begin
                        if (bus.skip || bus.goto) begin
                            pend <= 1'b1;
                        end
                        if (bus.sleep_req) begin
                            state <= ST_SLEEP;
                        end
                    end
                end
                ST_SLEEP: begin
                    q <= 2'd0;
                    if (bus.wake) begin
                        state <= ST_WAKE;
                        cnt   <= '0;
                    end
                end
                ST_WAKE: begin
                    // The instruction fetched before SLEEP is stale, so resume with a flush.
                    if (cnt == WAKE_LAST) begin
                        state <= ST_RUN;
                        q     <= 2'd0;
                        cnt   <= '0;
                        pend  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_START;
                end
            endcase
        end
    end

    assign running          = (state == ST_RUN);
    assign bus.fetchState   = running ? {1'b0, q} : PH_HALT;
    assign bus.executeState = running ? {1'b0, q} : PH_HALT;
    assign bus.flush        = running && (q == 2'd0) && pend;
    assign bus.inst_done    = running && (q == 2'd3);
    assign bus.sleeping     = (state == ST_SLEEP);

endmodule

// File: tb/tb_q_sequencer.sv
// Self-checking bench for q_sequencer: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the instruction cycle.
module tb_q_sequencer;

    localparam int STARTUP = 16;
    localparam int WAKE    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    q_sequencer_if bus ();

    q_sequencer #(
        .STARTUP_CLKS(STARTUP),
        .WAKE_CLKS   (WAKE),
        .CNT_W       (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: mode 0 = halted with a number of idle clocks left, 1 = running, 2 = asleep.
    int m_mode  = 0;
    int m_left  = 0;
    int m_phase = 0;
    bit m_flush_next = 1'b1;

    wire [8:0] dut_vec = {bus.fetchState, bus.executeState, bus.flush, bus.inst_done, bus.sleeping};

    function automatic logic [8:0] model_vec();
        logic [2:0] ph;
        ph = 3'(m_phase);
        case (m_mode)
            1:       return {ph, ph, (m_phase == 0) && m_flush_next, m_phase == 3, 1'b0};
            2:       return {3'd4, 3'd4, 1'b0, 1'b0, 1'b1};
            default: return {3'd4, 3'd4, 1'b0, 1'b0, 1'b0};
        endcase
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_mode = 0; m_left = STARTUP; m_phase = 0; m_flush_next = 1'b1;
        end else begin
            case (m_mode)
                0: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = 1; m_phase = 0;
                    end
                end
                1: begin
                    if (m_phase == 0) m_flush_next = 1'b0;
                    if (m_phase == 3) begin
                        if (bus.skip || bus.goto) m_flush_next = 1'b1;
                        m_phase = 0;
                        if (bus.sleep_req) m_mode = 2;
                    end else begin
                        m_phase++;
                    end
                end
                default: begin
                    if (bus.wake) begin
                        m_mode = 0; m_left = WAKE; m_flush_next = 1'b1;
                    end
                end
            endcase
        end
    endtask

    // One clock: model sees the same inputs the DUT samples, outputs are read 1ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic applyStimulus(input bit s, input bit g, input bit sl, input bit w);
        bus.skip = s; bus.goto = g; bus.sleep_req = sl; bus.wake = w;
    endtask

    task automatic advance_to_phase(input int p);
        int n;
        n = 0;
        while (!(m_mode == 1 && m_phase == p) && n < 64) begin
            step();
            n++;
        end
        if (n >= 64) begin
            total++; bad++;
            $display("[TB] FAIL advance_to_phase: timeout, phase %0d never reached", p);
        end
    endtask

    task automatic steps_until_run(output int n);
        n = 0;
        while (bus.fetchState == 3'd4 && n < 64) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        applyStimulus(0, 0, 0, 0);
        rst = 1'b1;
        step();
        step();
        total++;
        if (dut_vec !== 9'b100_100_000) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", dut_vec, 9'b100_100_000);
        end
        total++;
        if (dut_vec !== model_vec()) begin
            bad++;
            $display("[TB] FAIL reset_model: got %b expected %b", dut_vec, model_vec());
        end
    endtask

    task automatic test_startup();
        int n;
        int flushes;
        int dones;
        rst = 1'b0;
        steps_until_run(n);
        total++;
        if (n !== STARTUP) begin
            bad++;
            $display("[TB] FAIL startup_delay: got %0d clocks expected %0d", n, STARTUP);
        end
        total++;
        if ({bus.fetchState, bus.executeState, bus.flush} !== 7'b000_000_1) begin
            bad++;
            $display("[TB] FAIL first_q1_flush: got %b expected %b",
                     {bus.fetchState, bus.executeState, bus.flush}, 7'b000_000_1);
        end
        flushes = 0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            flushes += int'(bus.flush);
            dones   += int'(bus.inst_done);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++;
                $display("[TB] FAIL startup_run: got %b expected %b", dut_vec, model_vec());
            end
        end
        total++;
        if (flushes !== 0 || dones !== 3) begin
            bad++;
            $display("[TB] FAIL startup_counts: got flush=%0d done=%0d expected flush=0 done=3", flushes, dones);
        end
    endtask

    task automatic test_goto();
        int flushes;
        advance_to_phase(3);
        applyStimulus(0, 1, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0);
        total++;
        if ({bus.executeState, bus.flush} !== 4'b000_1) begin
            bad++;
            $display("[TB] FAIL goto_flush: got %b expected %b", {bus.executeState, bus.flush}, 4'b000_1);
        end
        flushes = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            flushes += int'(bus.flush);
        end
        total++;
        if (flushes !== 0) begin
            bad++;
            $display("[TB] FAIL goto_single: got %0d extra flushes expected 0", flushes);
        end
    endtask

    task automatic test_goto_q2();
        int flushes;
        advance_to_phase(1);
        applyStimulus(1, 1, 1, 0);
        step();
        applyStimulus(0, 0, 0, 0);
        flushes = 0;
        for (int i = 0; i < 8; i++) begin
            flushes += int'(bus.flush) + int'(bus.sleeping);
            step();
        end
        total++;
        if (flushes !== 0) begin
            bad++;
            $display("[TB] FAIL ignore_outside_q4: got %0d flush/sleep cycles expected 0", flushes);
        end
    endtask

    task automatic test_back_to_back();
        int flushes;
        advance_to_phase(3);
        applyStimulus(1, 1, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0);
        flushes = int'(bus.flush);
        for (int i = 0; i < 7; i++) begin
            step();
            flushes += int'(bus.flush);
        end
        total++;
        if (flushes !== 1) begin
            bad++;
            $display("[TB] FAIL skip_goto_single: got %0d flushes expected 1", flushes);
        end
    endtask

    task automatic test_sleep();
        int awake;
        advance_to_phase(3);
        applyStimulus(0, 0, 1, 0);
        total++;
        if (bus.inst_done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sleep_done: got %b expected 1", bus.inst_done);
        end
        step();
        applyStimulus(0, 0, 0, 0);
        total++;
        if (dut_vec !== 9'b100_100_001) begin
            bad++;
            $display("[TB] FAIL sleep_enter: got %b expected %b", dut_vec, 9'b100_100_001);
        end
        awake = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dut_vec !== 9'b100_100_001) awake++;
        end
        total++;
        if (awake !== 0) begin
            bad++;
            $display("[TB] FAIL sleep_hold: got %0d non-sleep cycles expected 0", awake);
        end
    endtask

    task automatic test_wake();
        int n;
        applyStimulus(0, 0, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0);
        total++;
        if (dut_vec !== 9'b100_100_000) begin
            bad++;
            $display("[TB] FAIL wake_leave: got %b expected %b", dut_vec, 9'b100_100_000);
        end
        steps_until_run(n);
        total++;
        if (n !== WAKE || bus.flush !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wake_resume: got %0d clocks flush=%b expected %0d flush=1", n, bus.flush, WAKE);
        end
    endtask

    task automatic test_sleep_goto_wake();
        int n;
        int flushes;
        advance_to_phase(3);
        applyStimulus(0, 1, 1, 1);
        step();
        applyStimulus(0, 0, 0, 1);
        total++;
        if (bus.sleeping !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sleep_one_clock: got sleeping=%b expected 1", bus.sleeping);
        end
        step();
        total++;
        if (dut_vec !== 9'b100_100_000) begin
            bad++;
            $display("[TB] FAIL sleep_to_wake: got %b expected %b", dut_vec, 9'b100_100_000);
        end
        steps_until_run(n);
        applyStimulus(0, 0, 0, 0);
        flushes = int'(bus.flush);
        for (int i = 0; i < 7; i++) begin
            step();
            flushes += int'(bus.flush);
        end
        total++;
        if (n !== WAKE || flushes !== 1) begin
            bad++;
            $display("[TB] FAIL sleep_goto_wake: got %0d clocks %0d flushes expected %0d clocks 1 flush",
                     n, flushes, WAKE);
        end
    endtask

    task automatic test_reset_mid_wake();
        int n;
        advance_to_phase(3);
        applyStimulus(0, 0, 1, 0);
        step();
        applyStimulus(0, 0, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (dut_vec !== 9'b100_100_000) begin
            bad++;
            $display("[TB] FAIL reset_mid_wake: got %b expected %b", dut_vec, 9'b100_100_000);
        end
        steps_until_run(n);
        total++;
        if (n !== STARTUP || bus.flush !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_mid_wake_delay: got %0d flush=%b expected %0d flush=1", n, bus.flush, STARTUP);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        advance_to_phase(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (dut_vec !== 9'b100_100_000) begin
            bad++;
            $display("[TB] FAIL reset_mid_run: got %b expected %b", dut_vec, 9'b100_100_000);
        end
        steps_until_run(n);
        total++;
        if (n !== STARTUP) begin
            bad++;
            $display("[TB] FAIL reset_mid_run_delay: got %0d expected %0d", n, STARTUP);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 4) == 0, ($urandom % 4) == 0,
                          ($urandom % 10) == 0, ($urandom % 6) == 0);
            rst = (($urandom % 300) == 0);
            step();
            total++;
            if (dut_vec !== model_vec()) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("[TB] FAIL random_cycle %0d: got %b expected %b", i, dut_vec, model_vec());
            end
        end
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0);
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0);
        test_reset();
        test_startup();
        test_goto();
        test_goto_q2();
        test_back_to_back();
        test_sleep();
        test_wake();
        test_sleep_goto_wake();
        test_reset_mid_wake();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/q_sequencer.md
Name: q_sequencer

Overview:
- Generates the four-phase instruction-cycle timing (Q1..Q4) for the PIC16C5x core. It drives `fetchState` and `executeState` to the instruction register, program counter and ALU.
- Controls power-on start-up delay, SLEEP entry and wake-up.
- Registers skip/goto requests and issues a one-clock pipeline flush in EX_Q1 of the next instruction cycle.

Parameters:
- STARTUP_CLKS, 16, clocks held idle after reset before the first Q1 (oscillator start-up).
- WAKE_CLKS, 8, clocks held idle after wake before resuming at Q1.
- CNT_W, 8, width of the delay counter; must hold max(STARTUP_CLKS, WAKE_CLKS).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- sleep_req  input  1  SLEEP instruction decoded; sampled only in EX_Q4.
- wake  input  1  wake source (WDT timeout/external), level.
- skip  input  1  skip condition from execute; sampled only in EX_Q4.
- goto  input  1  branch taken from execute; sampled only in EX_Q4.
- fetchState  output  3  0=FE_Q1, 1=FE_Q2, 2=FE_Q3, 3=FE_Q4, 4=FE_HALT.
- executeState  output  3  0=EX_Q1, 1=EX_Q2, 2=EX_Q3, 3=EX_Q4, 4=EX_HALT.
- flush  output  1  one-clock pulse, coincident with EX_Q1: the IR must be replaced by NOP.
- inst_done  output  1  one-clock pulse in EX_Q4 of every executed cycle.
- sleeping  output  1  high while in SLEEP.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Control FSM states: ST_START, ST_RUN, ST_SLEEP, ST_WAKE. 2-bit phase counter q. CNT_W-bit delay counter cnt. Registered pending flag pend.

Reset:
- rst=1 at a rising edge puts the block in ST_START with cnt=0, q=0 and pend=1. pend is set so that the first instruction executes as a NOP.
- Output values during and after reset: fetchState=4, executeState=4, flush=0, inst_done=0, sleeping=0.
- rst overrides every other input in every state, including mid-delay and mid-cycle.

ST_START:
- cnt increments each clock.
- When cnt==STARTUP_CLKS-1: go to ST_RUN with q=0 and cnt cleared.
- Outputs stay HALT during this state.

ST_RUN:
- q advances 0→1→2→3→0 every clock.
- fetchState=q and executeState=q (the same phase): fetch of instruction N+1 overlaps execute of N.
- flush = (q==0) & pend. pend clears when q==0.
- In q==3: inst_done=1, skip|goto → pend=1.
- In q==3 with sleep_req=1: next state is ST_SLEEP. The current cycle completes first; skip/goto is still recorded.
- First EX_Q1 after ST_START: flush=1, because pend was set by reset.

ST_SLEEP:
- fetchState=4, executeState=4, sleeping=1, q held at 0.
- wake=1 → go to ST_WAKE, cnt=0. sleeping drops in the same edge.
- If wake is already high when SLEEP is entered, ST_SLEEP still lasts exactly one clock.

ST_WAKE:
- Outputs HALT, sleeping=0, cnt increments.
- When cnt==WAKE_CLKS-1: go to ST_RUN at q=0 with pend forced to 1. The first resumed EX_Q1 flushes the instruction fetched before SLEEP.
- Deassertion of wake during ST_WAKE is ignored.

Ordering and timing rules:
- skip/goto/sleep_req outside EX_Q4 are ignored.
- skip and goto both high give a single flush.
- flush never asserts in any phase other than EX_Q1.
- inst_done never asserts in HALT states.

Test Plan:
- Reset then release, STARTUP_CLKS=16 → HALT for 16 clocks after rst falls. Then fetchState/executeState cycle 0,1,2,3. flush=1 on first EX_Q1 only. inst_done every 4th clock.
- In RUN, goto=1 during EX_Q4 → flush=1 for exactly the next EX_Q1. goto=1 during EX_Q2 → no flush. skip=goto=1 in EX_Q4 → one flush pulse.
- sleep_req=1 at EX_Q4 → that cycle completes with inst_done=1. Next clock: sleeping=1, both states=4. Stays there indefinitely with wake=0.
- Wake from sleep, WAKE_CLKS=8: wake pulse for 1 clock in SLEEP → sleeping=0 next clock. HALT for 8 clocks, then Q1 with flush=1.
- sleep_req and goto together at EX_Q4, wake held high → SLEEP for exactly 1 clock, WAKE for 8 clocks, then one flush at the first EX_Q1.
- rst=1 mid-ST_WAKE and mid-RUN (q=2) → next clock HALT outputs, cnt restarts. The full STARTUP_CLKS delay is observed again.
